// File: rtl/console_pkg.sv
// Shared definitions for the text console: default geometry, controller
// states and the control codes that the console interprets.
package console_pkg;

    localparam int DEF_COLS   = 80;
    localparam int DEF_ROWS   = 30;
    localparam int DEF_ADDR_W = 12;

    typedef enum logic [1:0] {
        ST_CLEAR   = 2'd0,
        ST_CLRLINE = 2'd1,
        ST_IDLE    = 2'd2
    } state_t;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_TILDE = 8'h7E;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= CH_SPACE) && (c <= CH_TILDE);
    endfunction

endpackage

// File: rtl/console_addr_map.sv
// Maps a logical (row, col) plus the scroll offset onto a character-RAM
// address. The row wrap is a single conditional subtract, no divider.
module console_addr_map #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input  logic [4:0]        row_i,
    input  logic [6:0]        col_i,
    input  logic [4:0]        off_i,
    output logic [ADDR_W-1:0] addr_o
);

    localparam logic [5:0] ROWS_W = 6'(ROWS);

    logic [5:0] row_sum;
    logic [4:0] phys_row;

    // physRow = (row + offset) mod ROWS, then row-major address
    always_comb begin
        row_sum = {1'b0, row_i} + {1'b0, off_i};
        if (row_sum >= ROWS_W) begin
            row_sum = row_sum - ROWS_W;
        end
        phys_row = row_sum[4:0];
        addr_o   = ADDR_W'(phys_row) * ADDR_W'(COLS) + ADDR_W'(col_i);
    end

endmodule

// File: rtl/text_console.sv
// Character-stream controller for the 80x30 text display.
// States:
//   ST_CLEAR   | writing 0x20 to every cell, addresses ascending
//   ST_CLRLINE | writing 0x20 across one physical row after a newline at the bottom
//   ST_IDLE    | accepting characters
// Build option CONSOLE_SCROLL_EN: when defined, a newline on the bottom row
// scrolls by rotating the row offset; otherwise the cursor wraps to row 0
// and that row is erased.
module text_console
    import console_pkg::*;
#(
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              iClk_50,
    input  logic              nRst,
    input  logic [7:0]        iChar,
    input  logic              iValid,
    output logic              oReady,
    output logic              oWrEn,
    output logic [ADDR_W-1:0] oWrAddr,
    output logic [7:0]        oWrData,
    output logic [4:0]        oRowOffset,
    output logic [4:0]        oCurRow,
    output logic [6:0]        oCurCol
);

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    state_t            state_q, state_d;
    logic [4:0]        row_q, row_d, off_q, off_d, clr_row_q, clr_row_d;
    logic [6:0]        col_q, col_d, clr_col_q, clr_col_d;
    logic              ready_q, ready_d, wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [4:0]        map_row, map_off;
    logic [6:0]        map_col;
    logic [ADDR_W-1:0] map_addr;
    logic              accept, newline;

    assign accept = iValid && ready_q && (state_q == ST_IDLE);

    console_addr_map #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) u_addr_map (
        .row_i  (map_row),
        .col_i  (map_col),
        .off_i  (map_off),
        .addr_o (map_addr)
    );

    // Address-map operands: clear counters while erasing, cursor otherwise
    // (backspace targets the cell left of the cursor).
    always_comb begin
        map_row = row_q;
        map_col = col_q;
        map_off = off_q;
        if (state_q != ST_IDLE) begin
            map_row = clr_row_q;
            map_col = clr_col_q;
            map_off = '0;
        end else if ((iChar == CH_BS) && (col_q != '0)) begin
            map_col = col_q - 7'd1;
        end
    end

    // Next-state, cursor movement and write generation
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        off_d     = off_q;
        clr_row_d = clr_row_q;
        clr_col_d = clr_col_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        newline   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = map_addr;
                wr_data_d = CH_SPACE;
                if (clr_col_q == LAST_COL) begin
                    clr_col_d = '0;
                    if (clr_row_q == LAST_ROW) begin
                        clr_row_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        clr_row_d = clr_row_q + 5'd1;
                    end
                end else begin
                    clr_col_d = clr_col_q + 7'd1;
                end
            end
            ST_CLRLINE: begin
                wr_en_d   = 1'b1;
                wr_addr_d = map_addr;
                wr_data_d = CH_SPACE;
                if (clr_col_q == LAST_COL) begin
                    clr_col_d = '0;
                    clr_row_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    clr_col_d = clr_col_q + 7'd1;
                end
            end
            default: begin
                if (accept) begin
                    if (is_printable(iChar)) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = map_addr;
                        wr_data_d = iChar;
                        if (col_q == LAST_COL) begin
                            col_d   = '0;
                            newline = 1'b1;
                        end else begin
                            col_d = col_q + 7'd1;
                        end
                    end else begin
                        case (iChar)
                            CH_LF: begin
                                col_d   = '0;
                                newline = 1'b1;
                            end
                            CH_CR: col_d = '0;
                            CH_BS: begin
                                if (col_q != '0) begin
                                    col_d     = col_q - 7'd1;
                                    wr_en_d   = 1'b1;
                                    wr_addr_d = map_addr;
                                    wr_data_d = CH_SPACE;
                                end
                            end
                            CH_FF: begin
                                row_d     = '0;
                                col_d     = '0;
                                off_d     = '0;
                                clr_row_d = '0;
                                clr_col_d = '0;
                                state_d   = ST_CLEAR;
                            end
                            default: ;
                        endcase
                    end
                    if (newline) begin
                        if (row_q != LAST_ROW) begin
                            row_d = row_q + 5'd1;
                        end else begin
`ifdef CONSOLE_SCROLL_EN
                            // old offset is the physical row that becomes the new bottom
                            off_d     = (off_q == LAST_ROW) ? 5'd0 : off_q + 5'd1;
                            clr_row_d = off_q;
`else
                            row_d     = '0;
                            clr_row_d = '0;
`endif
                            clr_col_d = '0;
                            state_d   = ST_CLRLINE;
                        end
                    end
                end
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // State, cursor and registered outputs
    always_ff @(posedge iClk_50 or negedge nRst) begin
        if (!nRst) begin
            state_q   <= ST_CLEAR;
            row_q     <= '0;
            col_q     <= '0;
            off_q     <= '0;
            clr_row_q <= '0;
            clr_col_q <= '0;
            ready_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            off_q     <= off_d;
            clr_row_q <= clr_row_d;
            clr_col_q <= clr_col_d;
            ready_q   <= ready_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign oReady     = ready_q;
    assign oWrEn      = wr_en_q;
    assign oWrAddr    = wr_addr_q;
    assign oWrData    = wr_data_q;
    assign oRowOffset = off_q;
    assign oCurRow    = row_q;
    assign oCurCol    = col_q;

endmodule

// File: tb/tb_text_console.sv
// Scoreboard bench for text_console: stimulus pushes expected RAM writes,
// a negedge monitor pops and compares every write strobe.
module tb_text_console;

    localparam int COLS = 80;
    localparam int ROWS = 30;
    localparam int CELLS = COLS * ROWS;
    localparam int LIMIT = 3000;

`ifdef CONSOLE_SCROLL_EN
    localparam int SCR_ROW = 29;
    localparam int SCR_OFF = 1;
`else
    localparam int SCR_ROW = 0;
    localparam int SCR_OFF = 0;
`endif

    logic        clk = 1'b0;
    logic        nRst;
    logic [7:0]  iChar;
    logic        iValid;
    logic        oReady, oWrEn;
    logic [11:0] oWrAddr;
    logic [7:0]  oWrData;
    logic [4:0]  oRowOffset, oCurRow;
    logic [6:0]  oCurCol;

    int checks = 0;
    int errors = 0;
    logic [19:0] expq[$];

    text_console dut (
        .iClk_50    (clk),
        .nRst       (nRst),
        .iChar      (iChar),
        .iValid     (iValid),
        .oReady     (oReady),
        .oWrEn      (oWrEn),
        .oWrAddr    (oWrAddr),
        .oWrData    (oWrData),
        .oRowOffset (oRowOffset),
        .oCurRow    (oCurRow),
        .oCurCol    (oCurCol)
    );

    always #5 clk = ~clk;

    // Monitor: every write strobe must match the head of the expected queue
    always @(negedge clk) begin
        if (oWrEn) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got addr=%0d data=%h, none expected", oWrAddr, oWrData);
            end else begin
                logic [19:0] e;
                e = expq.pop_front();
                if ({oWrAddr, oWrData} !== e) begin
                    errors++;
                    $display("FAIL write got addr=%0d data=%h, expected addr=%0d data=%h",
                             oWrAddr, oWrData, e[19:8], e[7:0]);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_w(input int addr, input logic [7:0] data);
        expq.push_back({12'(addr), data});
    endtask

    task automatic push_clear();
        for (int a = 0; a < CELLS; a++) push_w(a, 8'h20);
    endtask

    task automatic send(input logic [7:0] c);
        int n = 0;
        while (!oReady && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (!oReady) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got oReady=0 expected 1 for char %h", c);
        end else begin
            iChar  = c;
            iValid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            iValid = 1'b0;
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!oReady && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic chk_cursor(input string name, input int r, input int c, input int off);
        chk({name, "_row"}, int'(oCurRow), r);
        chk({name, "_col"}, int'(oCurCol), c);
        chk({name, "_off"}, int'(oRowOffset), off);
    endtask

    task automatic chk_drained(input string name);
        #1;
        chk({name, "_queue_left"}, expq.size(), 0);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_ready"}, int'(oReady), 0);
        chk({name, "_wren"}, int'(oWrEn), 0);
        chk({name, "_addr"}, int'(oWrAddr), 0);
        chk({name, "_data"}, int'(oWrData), 0);
        chk_cursor(name, 0, 0, 0);
    endtask

    initial begin
        int n;
        nRst   = 1'b0;
        iValid = 1'b0;
        iChar  = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");

        // power-up clear
        push_clear();
        nRst = 1'b1;
        wait_ready(n);
        chk("reset_clear_cycles", n, CELLS);
        chk_drained("reset_clear");
        chk_cursor("after_clear", 0, 0, 0);

        // "Hi" back-to-back
        push_w(0, 8'h48);
        push_w(1, 8'h69);
        send(8'h48);
        send(8'h69);
        chk_drained("hi");
        chk_cursor("hi", 0, 2, 0);

        // move to (5,10)
        send(8'h0D);
        for (int i = 0; i < 5; i++) send(8'h0A);
        for (int i = 0; i < 10; i++) begin
            push_w(400 + i, 8'h61 + 8'(i));
            send(8'h61 + 8'(i));
        end
        chk_cursor("at_5_10", 5, 10, 0);

        // backspace twice, ignored code, backspace at column 0
        push_w(409, 8'h20);
        push_w(408, 8'h20);
        send(8'h08);
        send(8'h08);
        chk_drained("bs");
        chk_cursor("bs", 5, 8, 0);
        send(8'h01);
        chk_cursor("ignored", 5, 8, 0);
        send(8'h0D);
        send(8'h08);
        chk_drained("bs_col0");
        chk_cursor("bs_col0", 5, 0, 0);

        // move to (29,79)
        for (int i = 0; i < 24; i++) send(8'h0A);
        for (int i = 0; i < 79; i++) begin
            push_w(29 * COLS + i, 8'h2E);
            send(8'h2E);
        end
        chk_cursor("at_29_79", 29, 79, 0);

        // printable at bottom-right: write then erase of the new bottom row
        push_w(2399, 8'h41);
        for (int i = 0; i < COLS; i++) push_w(i, 8'h20);
        send(8'h41);
        wait_ready(n);
        chk("scroll_busy_cycles", n, COLS);
        chk_drained("scroll");
        chk_cursor("scroll", SCR_ROW, 0, SCR_OFF);

        // writes land on physical row 0 after the scroll / wrap
        push_w(0, 8'h78);
        push_w(1, 8'h79);
        push_w(2, 8'h7A);
        push_w(3, 8'h42);
        send(8'h78);
        send(8'h79);
        send(8'h7A);
        send(8'h42);
        chk_drained("post_scroll");
        chk_cursor("post_scroll", SCR_ROW, 4, SCR_OFF);

        // form feed, with a held request whose data churns while busy
        push_clear();
        send(8'h0C);
        iValid = 1'b1;
        n = 0;
        while (!oReady && n < LIMIT) begin
            iChar = 8'h30 + 8'(n % 10);
            @(negedge clk);
            n++;
        end
        chk("ff_clear_cycles", n, CELLS);
        iChar = 8'h5A;
        push_w(0, 8'h5A);
        @(posedge clk);
        @(negedge clk);
        iValid = 1'b0;
        chk_drained("ff");
        chk_cursor("ff", 0, 1, 0);

        // reset in the middle of a line erase
        for (int i = 0; i < 29; i++) send(8'h0A);
        chk_cursor("pre_clrline", 29, 0, 0);
        for (int i = 0; i < 40; i++) push_w(i, 8'h20);
        send(8'h0A);
        repeat (40) @(negedge clk);
        #1 nRst = 1'b0;
        #1;
        chk_reset_vals("mid_reset");
        chk("mid_reset_queue_left", expq.size(), 0);
        @(negedge clk);
        push_clear();
        nRst = 1'b1;
        wait_ready(n);
        chk("restart_clear_cycles", n, CELLS);
        chk_drained("restart_clear");
        chk_cursor("restart", 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
